// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage:
// opcodes, condition codes, NZCV bit positions.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_BIC  = 3'b101;
  localparam logic [2:0] OP_MOVB = 3'b110;
  localparam logic [2:0] OP_MVN  = 3'b111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [3:0] {
    CC_EQ = 4'h0,
    CC_NE = 4'h1,
    CC_CS = 4'h2,
    CC_CC = 4'h3,
    CC_MI = 4'h4,
    CC_PL = 4'h5,
    CC_VS = 4'h6,
    CC_VC = 4'h7,
    CC_HI = 4'h8,
    CC_LS = 4'h9,
    CC_GE = 4'hA,
    CC_LT = 4'hB,
    CC_GT = 4'hC,
    CC_LE = 4'hD,
    CC_AL = 4'hE,
    CC_NV = 4'hF
  } cond_e;

  // ARM-style condition test against an NZCV snapshot
  function automatic logic cond_pass(
    input cond_e      c,
    input logic [3:0] f
  );
    logic n, z, cy, v, p;
    n  = f[FLAG_N];
    z  = f[FLAG_Z];
    cy = f[FLAG_C];
    v  = f[FLAG_V];
    p  = 1'b0;
    unique case (c)
      CC_EQ: p = z;
      CC_NE: p = ~z;
      CC_CS: p = cy;
      CC_CC: p = ~cy;
      CC_MI: p = n;
      CC_PL: p = ~n;
      CC_VS: p = v;
      CC_VC: p = ~v;
      CC_HI: p = cy & ~z;
      CC_LS: p = ~cy | z;
      CC_GE: p = (n == v);
      CC_LT: p = (n != v);
      CC_GT: p = ~z & (n == v);
      CC_LE: p = z | (n != v);
      CC_AL: p = 1'b1;
      CC_NV: p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/alu_exec_stage_alu.sv
// Combinational N-bit ALU producing a result
// and {N,Z,C,V}; C on SUB is ARM no-borrow.
module alu_exec_stage_alu
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [2:0]   op_i,
  output logic [N-1:0] y_o,
  output logic [3:0]   flags_o
);

  logic [N:0]   sum;
  logic [N-1:0] y;
  logic         c;
  logic         v;

  // Opcode decode: arithmetic sets C/V, logic clears them
  always_comb begin
    sum = '0;
    y   = '0;
    c   = 1'b0;
    v   = 1'b0;
    unique case (op_i)
      OP_ADD: begin
        sum = {1'b0, a_i} + {1'b0, b_i};
        y   = sum[N-1:0];
        c   = sum[N];
        v   = (a_i[N-1] == b_i[N-1]) &
              (y[N-1] != a_i[N-1]);
      end
      OP_SUB: begin
        sum = {1'b0, a_i} + {1'b0, ~b_i}
            + {{N{1'b0}}, 1'b1};
        y   = sum[N-1:0];
        c   = sum[N];
        v   = (a_i[N-1] != b_i[N-1]) &
              (y[N-1] != a_i[N-1]);
      end
      OP_AND:  y = a_i & b_i;
      OP_OR:   y = a_i | b_i;
      OP_XOR:  y = a_i ^ b_i;
      OP_BIC:  y = a_i & ~b_i;
      OP_MOVB: y = b_i;
      OP_MVN:  y = ~b_i;
      default: y = '0;
    endcase
  end

  assign y_o     = y;
  assign flags_o = {y[N-1], (y == '0), c, v};

endmodule

// File: rtl/alu_exec_stage.sv
// Registered execute stage: conditional ALU op,
// NZCV register, 2-entry result queue.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int N     = 4,
  parameter int DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [2:0]   opcode_i,
  input  logic [3:0]   cond_i,
  input  logic         set_flags_i,
  input  logic         flush_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [N-1:0] result_o,
  output logic [3:0]   flags_o,
  output logic         executed_o,
  output logic [3:0]   nzcv_o
);

  if (DEPTH != 2) begin : g_depth_chk
    $error("alu_exec_stage: DEPTH must be 2");
  end

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]   count_q, count_d;
  logic         head_q, head_d;
  logic [3:0]   nzcv_q, nzcv_d;
  logic [N-1:0] res_q [2];
  logic [3:0]   flg_q [2];
  logic         exe_q [2];

  logic [N-1:0] alu_y;
  logic [3:0]   alu_f;
  logic         push;
  logic         pop;
  logic         pass;
  logic         wr_idx;
  logic [N-1:0] ent_res;
  logic [3:0]   ent_flg;

  alu_exec_stage_alu #(.N(N)) u_alu (
    .a_i     (a_i),
    .b_i     (b_i),
    .op_i    (opcode_i),
    .y_o     (alu_y),
    .flags_o (alu_f)
  );

  assign in_ready_o  = (count_q != ST_FULL)
                     & rst_ni & ~flush_i;
  assign out_valid_o = (count_q != ST_EMPTY);
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;
  assign pass        = cond_pass(cond_e'(cond_i),
                                 nzcv_q);
  // Tail slot sits just past the head when one
  // entry is already held.
  assign wr_idx      = head_q ^ count_q[0];
  assign ent_res     = pass ? alu_y : '0;
  assign ent_flg     = pass ? alu_f : nzcv_q;

  // Occupancy FSM, head pointer and flag update
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    nzcv_d  = nzcv_q;
    unique case (count_q)
      ST_EMPTY: if (push) count_d = ST_ONE;
      ST_ONE: begin
        if (push & ~pop)      count_d = ST_FULL;
        else if (pop & ~push) count_d = ST_EMPTY;
      end
      ST_FULL:  if (pop) count_d = ST_ONE;
      default:  count_d = ST_EMPTY;
    endcase
    if (flush_i) count_d = ST_EMPTY;
    if (pop)     head_d  = ~head_q;
    if (push & pass & set_flags_i)
      nzcv_d = alu_f;
  end

  // Control and flag state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= ST_EMPTY;
      head_q  <= 1'b0;
      nzcv_q  <= 4'b0000;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      nzcv_q  <= nzcv_d;
    end
  end

  // Queue storage, written at the tail on push
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) begin
        res_q[i] <= '0;
        flg_q[i] <= '0;
        exe_q[i] <= 1'b0;
      end
    end else if (push) begin
      res_q[wr_idx] <= ent_res;
      flg_q[wr_idx] <= ent_flg;
      exe_q[wr_idx] <= pass;
    end
  end

  assign result_o   = out_valid_o
                    ? res_q[head_q] : '0;
  assign flags_o    = out_valid_o
                    ? flg_q[head_q] : 4'b0000;
  assign executed_o = out_valid_o & exe_q[head_q];
  assign nzcv_o     = nzcv_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Testbench for alu_exec_stage: directed
// scenarios plus random traffic vs a queue model.
module tb_alu_exec_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready_o;
  logic [3:0] a, b;
  logic [2:0] op;
  logic [3:0] cond;
  logic       sf;
  logic       flush;
  logic       out_valid_o;
  logic       out_ready;
  logic [3:0] result_o;
  logic [3:0] flags_o;
  logic       executed_o;
  logic [3:0] nzcv_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int r;
    int f;
    int e;
  } entry_t;

  entry_t mq[$];
  int     mnzcv;
  int     got_q[$];

  always #5 clk = ~clk;

  alu_exec_stage #(.N(4), .DEPTH(2)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready_o),
    .a_i         (a),
    .b_i         (b),
    .opcode_i    (op),
    .cond_i      (cond),
    .set_flags_i (sf),
    .flush_i     (flush),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready),
    .result_o    (result_o),
    .flags_o     (flags_o),
    .executed_o  (executed_o),
    .nzcv_o      (nzcv_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic int sx(input int x);
    return (x >= 8) ? x - 16 : x;
  endfunction

  // Reference ALU in plain integer arithmetic
  function automatic void ref_alu(
    input int o, input int x, input int y,
    output int r, output int f);
    int s, c, v;
    c = 0;
    v = 0;
    r = 0;
    case (o)
      0: begin
        s = x + y;
        r = s % 16;
        c = (s > 15);
        s = sx(x) + sx(y);
        v = (s > 7 || s < -8);
      end
      1: begin
        r = (x - y + 16) % 16;
        c = (x >= y);
        s = sx(x) - sx(y);
        v = (s > 7 || s < -8);
      end
      2: r = x & y;
      3: r = x | y;
      4: r = x ^ y;
      5: r = x & (~y & 15);
      6: r = y;
      default: r = ~y & 15;
    endcase
    f = (r >= 8) * 8 + (r == 0) * 4 + c * 2 + v;
  endfunction

  function automatic int ref_cond(input int c,
                                  input int f);
    bit n, z, cy, v;
    n  = (f / 8) % 2 == 1;
    z  = (f / 4) % 2 == 1;
    cy = (f / 2) % 2 == 1;
    v  = f % 2 == 1;
    case (c)
      0:  return int'(z);
      1:  return int'(!z);
      2:  return int'(cy);
      3:  return int'(!cy);
      4:  return int'(n);
      5:  return int'(!n);
      6:  return int'(v);
      7:  return int'(!v);
      8:  return int'(cy && !z);
      9:  return int'(!cy || z);
      10: return int'(n == v);
      11: return int'(n != v);
      12: return int'(!z && n == v);
      13: return int'(z || n != v);
      14: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic set_in(input int o, input int x,
                        input int y, input int c,
                        input int s);
    in_valid = 1'b1;
    op   = 3'(o);
    a    = 4'(x);
    b    = 4'(y);
    cond = 4'(c);
    sf   = 1'(s);
  endtask

  // One clock: check outputs, then advance model
  task automatic step();
    bit     mready, push, pop;
    int     r, f, p;
    entry_t e;
    @(negedge clk);
    mready = (mq.size() < 2) && !flush;
    chk("in_ready", 32'(in_ready_o), 32'(mready));
    chk("out_valid", 32'(out_valid_o),
        32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("result", 32'(result_o), mq[0].r);
      chk("flags", 32'(flags_o), mq[0].f);
      chk("executed", 32'(executed_o), mq[0].e);
    end else begin
      chk("idle_result", 32'(result_o), 0);
    end
    chk("nzcv", 32'(nzcv_o), mnzcv);
    push = in_valid && mready;
    pop  = (mq.size() > 0) && out_ready;
    if (pop) got_q.push_back(int'(result_o));
    e = '{0, 0, 0};
    p = 0;
    if (push) begin
      ref_alu(int'(op), int'(a), int'(b), r, f);
      p = ref_cond(int'(cond), mnzcv);
      if (p != 0) e = '{r, f, 1};
      else        e = '{0, mnzcv, 0};
    end
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (push) begin
      mq.push_back(e);
      if (p != 0 && sf) mnzcv = e.f;
    end
    if (flush) mq.delete();
    #1;
    if (push) in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    op        = '0;
    cond      = '0;
    sf        = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    mnzcv     = 0;

    // 1: reset and idle
    #2;
    chk("rst_ready", 32'(in_ready_o), 0);
    chk("rst_valid", 32'(out_valid_o), 0);
    chk("rst_result", 32'(result_o), 0);
    chk("rst_flags", 32'(flags_o), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_ready", 32'(in_ready_o), 1);
    chk("idle_valid", 32'(out_valid_o), 0);
    chk("idle_nzcv", 32'(nzcv_o), 0);
    step();

    // 2: SUB 5-5 AL, set flags
    set_in(1, 5, 5, 14, 1);
    step();
    chk("sub_result", 32'(result_o), 0);
    chk("sub_flags", 32'(flags_o), 32'b0110);
    chk("sub_exec", 32'(executed_o), 1);
    chk("sub_nzcv", 32'(nzcv_o), 32'b0110);
    out_ready = 1'b1;
    step();

    // 3: ADD under EQ then NE
    set_in(0, 3, 4, 0, 0);
    step();
    chk("eq_exec", 32'(executed_o), 1);
    chk("eq_result", 32'(result_o), 32'b0111);
    set_in(0, 3, 4, 1, 0);
    step();
    chk("ne_exec", 32'(executed_o), 0);
    chk("ne_result", 32'(result_o), 0);
    chk("ne_nzcv", 32'(nzcv_o), 32'b0110);
    step();

    // 4: stall at full, then ordered drain
    out_ready = 1'b0;
    got_q.delete();
    set_in(6, 0, 1, 14, 0);
    step();
    set_in(6, 0, 2, 14, 0);
    step();
    chk("full_ready", 32'(in_ready_o), 0);
    set_in(6, 0, 3, 14, 0);
    step();
    step();
    chk("stall_held", 32'(in_valid), 1);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("drain_cnt", got_q.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < got_q.size())
        chk("drain_order", got_q[i], i + 1);

    // 5: flush while full with a push attempt
    out_ready = 1'b0;
    set_in(6, 0, 4, 14, 0);
    step();
    set_in(6, 0, 5, 14, 0);
    step();
    set_in(6, 0, 6, 14, 0);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 32'(out_valid_o), 0);
    chk("flush_nzcv", 32'(nzcv_o), 32'b0110);
    step();
    chk("flush_nopush", 32'(out_valid_o), 0);

    // 6: async reset with two ops queued
    set_in(1, 2, 3, 14, 1);
    step();
    set_in(6, 0, 9, 14, 0);
    step();
    chk("pre_rst_nzcv", 32'(nzcv_o), 32'b1000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid_o), 0);
    chk("arst_nzcv", 32'(nzcv_o), 0);
    chk("arst_ready", 32'(in_ready_o), 0);
    mq.delete();
    mnzcv = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    set_in(0, 7, 1, 14, 1);
    step();
    chk("resume_result", 32'(result_o), 8);
    chk("resume_nzcv", 32'(nzcv_o), 32'b1001);
    step();

    // Random traffic against the model
    for (int i = 0; i < 500; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      op        = 3'($urandom_range(0, 7));
      a         = 4'($urandom_range(0, 15));
      b         = 4'($urandom_range(0, 15));
      cond      = 4'($urandom_range(0, 15));
      sf        = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 19) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
